// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake to uart_tx; source drives txData/txValid, transmitter drives txReady/txBusy
interface uart_tx_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] txData;
  logic txValid;
  logic txReady;
  logic txBusy;
  modport master(output txData, txValid, input txReady, txBusy);
  modport slave(input txData, txValid, output txReady, txBusy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter; clk, rst (async active-low), baudEn (oversample tick), bus (byte handshake), txd (serial line, idle high)
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input logic clk,
  input logic rst,
  input logic baudEn,
  uart_tx_if.slave bus,
  output logic txd
);
  localparam int TW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, PAR, STOP} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] tick;
  logic [BW-1:0] bit_cnt;
  logic stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic par, rdy, busy, txd_nxt, rdy_nxt, busy_nxt;
  logic accept, bit_end, last_data, last_stop;
  assign accept = bus.txValid && rdy;
  assign bit_end = baudEn && tick == LAST_TICK;
  assign last_data = bit_cnt == LAST_BIT;
  assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
  assign bus.txReady = rdy;
  assign bus.txBusy = busy;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      tick <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      shreg <= '0;
      par <= 1'b0;
      txd <= 1'b1;
      rdy <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      txd <= txd_nxt;
      rdy <= rdy_nxt;
      busy <= busy_nxt;
      tick <= (state == IDLE || state == ARM || bit_end) ? '0 : tick + TW'(baudEn);
      bit_cnt <= state != DATA ? '0 : bit_cnt + BW'(bit_end);
      stop_cnt <= state == STOP ? stop_cnt ^ bit_end : 1'b0;
      shreg <= accept ? bus.txData : (state == DATA && bit_end) ? shreg >> 1 : shreg;
      par <= accept ? (PARITY == 1 ? ~^bus.txData : ^bus.txData) : par;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? ARM : IDLE;
      ARM: state_nxt = baudEn ? START : ARM;
      START: state_nxt = bit_end ? DATA : START;
      DATA: state_nxt = (bit_end && last_data) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR: state_nxt = bit_end ? STOP : PAR;
      STOP: state_nxt = (bit_end && last_stop) ? IDLE : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    txd_nxt = txd;
    rdy_nxt = rdy;
    busy_nxt = busy;
    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        rdy_nxt = !accept;
        busy_nxt = accept;
      end
      ARM: txd_nxt = baudEn ? 1'b0 : txd;
      START: txd_nxt = bit_end ? shreg[0] : txd;
      DATA: txd_nxt = !bit_end ? txd : !last_data ? shreg[1] : PARITY != 0 ? par : 1'b1;
      PAR: txd_nxt = bit_end ? 1'b1 : txd;
      STOP: begin
        rdy_nxt = bit_end && last_stop;
        busy_nxt = !(bit_end && last_stop);
      end
      default: begin
        txd_nxt = 1'b1;
        rdy_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frame checks for uart_tx in default, odd-parity and even-parity/two-stop builds
module tb_uart_tx;
  typedef struct {
    int sel;
    logic [7:0] data;
    int n;
    logic [11:0] fr;
    int div;
  } vec_t;
  localparam int NV = 9;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic baudEn = 1'b0;
  logic txd0, txd1, txd2, txd_s, rdy_s, busy_s;
  int sel = 0;
  int bdiv = 4;
  int bc = 0;
  int nvec = 0;
  int nerr = 0;
  vec_t tbl [NV];
  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();
  uart_tx u0 (.clk(clk), .rst(rst), .baudEn(baudEn), .bus(if0), .txd(txd0));
  uart_tx #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .baudEn(baudEn), .bus(if1), .txd(txd1));
  uart_tx #(.PARITY(2), .STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .baudEn(baudEn), .bus(if2), .txd(txd2));
  assign txd_s = sel == 0 ? txd0 : sel == 1 ? txd1 : txd2;
  assign rdy_s = sel == 0 ? if0.txReady : sel == 1 ? if1.txReady : if2.txReady;
  assign busy_s = sel == 0 ? if0.txBusy : sel == 1 ? if1.txBusy : if2.txBusy;
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    bc++;
    baudEn = bc % bdiv == 0;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] v, input logic [7:0] d);
    if0.txValid = v[0];
    if1.txValid = v[1];
    if2.txValid = v[2];
    if0.txData = d;
    if1.txData = d;
    if2.txData = d;
  endtask
  task automatic send(input int s, input logic [7:0] d, input bit hold);
    @(negedge clk);
    sel = s;
    drive(3'(1 << s), d);
    step();
    check($sformatf("accept u%0d %0h", s, d), {10'd0, rdy_s, busy_s}, 12'b01);
    if (!hold) begin
      @(negedge clk);
      drive(3'b000, d);
    end
  endtask
  task automatic recv(input int n, input logic [11:0] fr, input string tag, output int gap);
    int p;
    logic v, stab;
    p = 16 * bdiv;
    gap = 0;
    while (txd_s !== 1'b0 && gap < 200) begin
      step();
      gap++;
    end
    check({tag, " start"}, {11'd0, txd_s}, 12'd0);
    if (txd_s !== 1'b0) return;
    for (int k = 0; k < n; k++) begin
      v = txd_s;
      stab = 1'b1;
      for (int c = 1; c < p; c++) begin
        step();
        if (txd_s !== v || busy_s !== 1'b1 || rdy_s !== 1'b0) stab = 1'b0;
      end
      check($sformatf("%s bit%0d", tag, k), {11'd0, v}, {11'd0, fr[k]});
      check($sformatf("%s hold%0d", tag, k), {11'd0, stab}, 12'd1);
      step();
    end
    check({tag, " end"}, {9'd0, rdy_s, busy_s, txd_s}, 12'b101);
  endtask
  initial begin
    int g;
    tbl[0] = '{0, 8'h55, 10, 12'h2AA, 4};
    tbl[1] = '{0, 8'hA5, 10, 12'h34A, 4};
    tbl[2] = '{0, 8'h00, 10, 12'h200, 4};
    tbl[3] = '{0, 8'hFF, 10, 12'h3FE, 4};
    tbl[4] = '{1, 8'h55, 11, 12'h6AA, 4};
    tbl[5] = '{1, 8'h07, 11, 12'h40E, 4};
    tbl[6] = '{2, 8'h03, 12, 12'hC06, 4};
    tbl[7] = '{2, 8'h01, 12, 12'hE02, 4};
    tbl[8] = '{0, 8'h55, 10, 12'h2AA, 1};
    drive(3'b111, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(i % 2 == 0 ? 3'b111 : 3'b000, 8'hFF);
      repeat (3) step();
      check($sformatf("rst u0 %0d", i), {9'd0, if0.txReady, if0.txBusy, txd0}, 12'b101);
      check($sformatf("rst u1 %0d", i), {9'd0, if1.txReady, if1.txBusy, txd1}, 12'b101);
      check($sformatf("rst u2 %0d", i), {9'd0, if2.txReady, if2.txBusy, txd2}, 12'b101);
    end
    @(negedge clk);
    drive(3'b000, 8'hFF);
    rst = 1'b1;
    repeat (20) step();
    check("idle after rst", {9'd0, if0.txReady, if0.txBusy, txd0}, 12'b101);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bdiv = tbl[i].div;
      repeat (4) step();
      send(tbl[i].sel, tbl[i].data, 1'b0);
      recv(tbl[i].n, tbl[i].fr, $sformatf("v%0d", i), g);
    end
    @(negedge clk);
    bdiv = 4;
    repeat (8) step();
    send(2, 8'hA5, 1'b1);
    @(negedge clk);
    drive(3'b100, 8'h3C);
    recv(12, 12'hD4A, "b2b A5", g);
    step();
    check("b2b accept", {10'd0, rdy_s, busy_s}, 12'b01);
    @(negedge clk);
    drive(3'b000, 8'h3C);
    recv(12, 12'hC78, "b2b 3C", g);
    check("b2b gap", {11'd0, g + 1 <= 4}, 12'd1);
    send(0, 8'h12, 1'b1);
    @(negedge clk);
    drive(3'b001, 8'hEF);
    recv(10, 12'h224, "chg 12", g);
    step();
    check("chg accept", {10'd0, rdy_s, busy_s}, 12'b01);
    @(negedge clk);
    drive(3'b000, 8'hEF);
    recv(10, 12'h3DE, "chg EF", g);
    send(0, 8'hC3, 1'b0);
    g = 0;
    while (txd0 !== 1'b0 && g < 200) begin
      step();
      g++;
    end
    repeat (4 * 64 + 32) step();
    check("c3 bit3 low", {11'd0, txd0}, 12'd0);
    #1;
    rst = 1'b0;
    #1;
    check("async rst", {9'd0, if0.txReady, if0.txBusy, txd0}, 12'b101);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) step();
    check("after rst idle", {9'd0, if0.txReady, if0.txBusy, txd0}, 12'b101);
    send(0, 8'h81, 1'b0);
    recv(10, 12'h302, "post rst 81", g);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises parallel bytes onto a single TX line. It consumes the single-cycle baud strobe produced by the team's baud-rate generator, treating each strobe as one oversample tick. It sits between a byte source (a command or telemetry FIFO) and the board TX pin, and is the transmit-side counterpart of the baud generator/receiver path. Frames are start bit, LSB-first data, optional parity, and 1 or 2 stop bits.

Parameters:
OVERSAMPLE, 16, baudEn pulses per bit period; legal range 2..256.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  asynchronous, active-low reset.
baudEn  input  1  one-clk-wide oversample tick from the baud generator.
txData  input  DATA_BITS  byte to send; sampled only on acceptance.
txValid  input  1  source has txData available.
txReady  output  1  transmitter can accept a byte this cycle.
txBusy  output  1  frame in progress, from acceptance to end of the last stop bit.
txd  output  1  serial line; idle high.

Behaviour:
- Reset (rst low, asynchronous):
  - txd = 1, txReady = 1, txBusy = 0.
  - State = IDLE; all counters and the shift register cleared.
  - Reset asserted mid-frame aborts the frame and forces txd high immediately. No partial frame resumes after release.
- All outputs are registered.
- Handshake:
  - Acceptance occurs on a clk edge where txValid && txReady.
  - txData is latched into the shift register on that edge.
  - On the same edge: txReady drops to 0 and txBusy rises to 1.
  - txValid without txReady is ignored. The source must hold its data; nothing is lost or latched.
- States: IDLE -> ARM -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
- IDLE: txd = 1, txReady = 1. baudEn is ignored.
- ARM: wait for the next baudEn pulse. On it, txd <= 0, tick counter <= 0, go to START. This aligns every bit to a tick boundary, so all bits last exactly OVERSAMPLE ticks.
- Tick counter: counts baudEn pulses within the current bit, width clog2(OVERSAMPLE). A bit ends on the baudEn pulse where the counter equals OVERSAMPLE-1. On that pulse the counter wraps to 0 and the next bit value is registered onto txd.
- START: ends after OVERSAMPLE ticks; txd <= shift register bit 0; go to DATA.
- DATA:
  - Shift right on each bit end.
  - The bit counter counts DATA_BITS bits; LSB is sent first.
  - After the last data bit, go to PARITY or STOP.
- PARITY:
  - Odd mode: txd = ~^data.
  - Even mode: txd = ^data.
  - Parity is computed from the latched byte, not from the live txData.
- STOP:
  - txd = 1 for STOP_BITS × OVERSAMPLE ticks.
  - On the final stop-bit end: go to IDLE, txReady <= 1, txBusy <= 0 (visible the next cycle).
- Back-to-back frames: a byte accepted in the cycle txReady returns high goes through ARM. The inter-frame gap is at most one baudEn period beyond the stop bit(s).
- baudEn asserted on consecutive clocks: each pulse counts as one tick. There is no minimum spacing.
- txData changing after acceptance has no effect on the frame in flight.
- Frame duration from the first ARM tick: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × OVERSAMPLE baudEn pulses.

Test Plan:
- Reset: hold rst low, toggle txValid with txData = 0xFF, pulse baudEn -> txd = 1, txReady = 1, txBusy = 0 throughout; no frame starts.
- Default params, baudEn every 4 clks, send 0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each level exactly 64 clks; txBusy high from acceptance until the stop-bit end; txReady returns to 1 one cycle later.
- PARITY=1 sending 0x55 -> parity bit = 1. PARITY=2 sending 0x03 -> parity bit = 0. Frame length = 11 bits × 16 ticks.
- STOP_BITS=2, back-to-back 0xA5 then 0x3C with txValid held high -> second start bit begins within one baudEn period after 32 ticks of stop. Both bytes are decoded correctly by a bench receiver model.
- Pull rst low during data bit 3 of 0xC3 -> txd = 1 within the same cycle as the reset assertion (asynchronous); after release, txReady = 1 and the next accepted byte 0x81 is transmitted cleanly.
- Change txData from 0x12 to 0xEF one cycle after acceptance; hold txValid high while txReady = 0 -> line carries 0x12; 0xEF is accepted only after txReady rises.
